mdu_sched: RTL and testbench
============================

Name: mdu_sched

Overview:
Multi-cycle multiply/divide unit and its scheduler for the 5-stage pipeline (P6 extension). It sits in the EX stage and accepts mult/multu/div/divu/mthi/mtlo from the EX-stage controller. It sequences a fixed-latency operation, owns the HI/LO registers, and raises a stall request into the hazard unit while any MD-class instruction in D would observe an unfinished result.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15)
DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15)

Ports:
clk  input  1  pipeline clock
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse from EX: launch the op on md_op
md_op  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6-7 reserved (no-op)
a  input  32  forwarded rs value (MFRSE)
b  input  32  forwarded rt value (MFRTE)
md_use_d  input  1  instruction in D is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
busy  output  1  operation in progress
hi  output  32  HI register
lo  output  32  LO register
stall_md  output  1  stall request, ORed into StallF/StallD/FlushE
done  output  1  one-cycle pulse on the cycle HI/LO take the result

Behaviour:
- Reset (asynchronous, active-high): state IDLE, busy=0, done=0, hi=0, lo=0, cnt=0, result latches=0. Reset mid-operation aborts it and discards the result.
- FSM states: IDLE, RUN.
- IDLE, start=1, md_op 0..3:
  - compute the result at the clock edge into pending_hi/pending_lo;
  - load cnt = MULT_CYCLES or DIV_CYCLES;
  - go to RUN. busy rises the cycle after start.
- Result values:
  - mult: signed 32x32 -> 64, hi=[63:32], lo=[31:0].
  - multu: unsigned 32x32 -> 64, same split.
  - div: signed; lo = quotient truncated toward zero, hi = remainder with the sign of a.
  - divu: unsigned; lo = quotient, hi = remainder.
  - Divide by zero: pending values equal current hi/lo, so HI/LO are unchanged. The full DIV_CYCLES latency still applies.
- IDLE, start=1, md_op 4: hi <= a at that edge. md_op 5: lo <= a at that edge. No busy, no done. md_op 6/7: ignored.
- RUN: cnt decrements each cycle. On the edge where cnt==1: hi/lo <= pending, done=1 for the following cycle, state IDLE, busy=0.
- start while RUN: ignored, no effect on the counter or results. The stall logic must prevent this case.
- stall_md = md_use_d & (start | busy), combinational. start counts because busy is not yet visible in the cycle the op is in EX.
- hi/lo change only at the completion edge or on an mthi/mtlo edge. Reads are never torn.
- Busy cycle count is exactly N; an MD instruction in D issues in the first cycle with busy=0.
- No interaction with branch/jump flush. An MD op that reached EX is committed.

Optional Feature:
- Macro: MDU_DIV0_FAST_EN.
- Defined: div/divu with b==0 loads cnt=1, giving 1 busy cycle. HI/LO are still unchanged and done still pulses.
- Undefined: divide by zero takes the full DIV_CYCLES latency, as above.

Test Plan:
- mult, a=0xFFFFFFFE (-2), b=3 -> busy high for 5 cycles starting cycle+1; then hi=0xFFFFFFFF, lo=0xFFFFFFFA; done pulses once.
- multu, a=0xFFFFFFFF, b=0xFFFFFFFF -> after 5 busy cycles hi=0xFFFFFFFE, lo=0x00000001.
- div, a=-7 (0xFFFFFFF9), b=2 -> 10 busy cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then divu, a=7, b=0 -> hi/lo unchanged (10 cycles, or 1 cycle with MDU_DIV0_FAST_EN).
- mthi a=0x12345678, then mtlo a=0x9ABCDEF0 on consecutive cycles -> hi/lo update at each edge; busy stays 0; stall_md=0.
- mult start with md_use_d=1 (mflo in D) -> stall_md=1 on the start cycle and all 5 busy cycles, 0 on the next. A second start while busy is ignored and the result is from the first op.
- reset asserted asynchronously at busy cycle 3 of div -> busy, done, hi and lo go to 0 immediately with no clock edge; no done pulse afterward.

Source files
------------

// File: rtl/mdu_sched.sv
// mdu_sched: multi-cycle multiply/divide unit with HI/LO ownership and
// MD-class stall generation for the EX stage of the 5-stage pipeline.
//
// Ports:
//   clk, reset      pipeline clock, asynchronous active-high reset
//   start, md_op    one-cycle launch pulse and op select
//                   (0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6-7 no-op)
//   a, b            forwarded rs / rt operands
//   md_use_d        instruction in D is an MD-class instruction
//   busy            operation in progress
//   hi, lo          architectural HI / LO registers
//   stall_md        combinational stall request into the hazard unit
//   done            one-cycle pulse on the cycle HI/LO take a result
//
// Optional feature: define MDU_DIV0_FAST_EN to complete div/divu by zero
// after a single busy cycle instead of the full DIV_CYCLES latency.
module mdu_sched #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        md_use_d,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        stall_md,
    output logic        done
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);
`ifdef MDU_DIV0_FAST_EN
    localparam logic [CNT_W-1:0] DIV0_CNT = CNT_W'(1);
`else
    localparam logic [CNT_W-1:0] DIV0_CNT = CNT_W'(DIV_CYCLES);
`endif

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      pend_hi_q, pend_hi_d;
    logic [31:0]      pend_lo_q, pend_lo_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic             done_q, done_d;

    // Arithmetic datapath, evaluated from the operands presented with start.
    logic [63:0] prod_s, prod_u;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic [31:0] quo_mag, rem_mag;
    logic [31:0] quo_s, rem_s;
    logic [31:0] quo_u, rem_u;
    logic        div_zero;

    // Sign-extended 64-bit operands give the exact signed product in 64 bits.
    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide through magnitudes so the most-negative dividend is well defined.
    assign a_neg    = a[31];
    assign b_neg    = b[31];
    assign a_mag    = a_neg ? (32'd0 - a) : a;
    assign b_mag    = b_neg ? (32'd0 - b) : b;
    assign div_zero = (b == 32'd0);
    assign quo_mag  = div_zero ? 32'd0 : (a_mag / b_mag);
    assign rem_mag  = div_zero ? 32'd0 : (a_mag % b_mag);
    assign quo_s    = (a_neg ^ b_neg) ? (32'd0 - quo_mag) : quo_mag;
    assign rem_s    = a_neg ? (32'd0 - rem_mag) : rem_mag;
    assign quo_u    = div_zero ? 32'd0 : (a / b);
    assign rem_u    = div_zero ? 32'd0 : (a % b);

    // State and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    // Next-state: launch in IDLE, count down in RUN, commit on the last busy cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (md_op)
                        OP_MULT: begin
                            pend_hi_d = prod_s[63:32];
                            pend_lo_d = prod_s[31:0];
                            cnt_d     = MULT_CNT;
                            state_d   = S_RUN;
                        end
                        OP_MULTU: begin
                            pend_hi_d = prod_u[63:32];
                            pend_lo_d = prod_u[31:0];
                            cnt_d     = MULT_CNT;
                            state_d   = S_RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            // Divide by zero commits the current HI/LO, i.e. no change.
                            if (div_zero) begin
                                pend_hi_d = hi_q;
                                pend_lo_d = lo_q;
                                cnt_d     = DIV0_CNT;
                            end else begin
                                pend_hi_d = (md_op == OP_DIV) ? rem_s : rem_u;
                                pend_lo_d = (md_op == OP_DIV) ? quo_s : quo_u;
                                cnt_d     = DIV_CNT;
                            end
                            state_d = S_RUN;
                        end
                        OP_MTHI: hi_d = a;
                        OP_MTLO: lo_d = a;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                // start is ignored here; the stall logic keeps it from happening.
                if (cnt_q <= CNT_W'(1)) begin
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy = (state_q == S_RUN);
    assign hi   = hi_q;
    assign lo   = lo_q;
    assign done = done_q;

    // start counts too: busy is not visible yet while the op sits in EX.
    assign stall_md = md_use_d & (start | busy);

endmodule

// File: tb/tb_mdu_sched.sv
// tb_mdu_sched: self-checking bench for mdu_sched with directed cases and a
// randomized run compared against a longint-arithmetic reference model.
module tb_mdu_sched;

    localparam int MC = 5;
    localparam int DC = 10;
`ifdef MDU_DIV0_FAST_EN
    localparam int D0C = 1;
`else
    localparam int D0C = DC;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        md_use_d;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        stall_md;
    logic        done;

    int checks   = 0;
    int failures = 0;

    // Reference HI/LO as the architecture defines them.
    logic [31:0] mhi = 32'd0;
    logic [31:0] mlo = 32'd0;

    always #5 clk = ~clk;

    mdu_sched #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .md_op    (md_op),
        .a        (op_a),
        .b        (op_b),
        .md_use_d (md_use_d),
        .busy     (busy),
        .hi       (hi),
        .lo       (lo),
        .stall_md (stall_md),
        .done     (done)
    );

    // Reference model: updates mhi/mlo and returns the expected busy-cycle count.
    function automatic int model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        longint          sx, sy, sp, sq, sr;
        longint unsigned up;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (op)
            3'd0: begin
                sp = sx * sy;
                mhi = 32'(sp >>> 32); mlo = 32'(sp);
                return MC;
            end
            3'd1: begin
                up = longint'(x) * longint'(y);
                mhi = 32'(up >> 32); mlo = 32'(up);
                return MC;
            end
            3'd2: begin
                if (y == 32'd0) return D0C;
                sq = sx / sy; sr = sx % sy;
                mlo = 32'(sq); mhi = 32'(sr);
                return DC;
            end
            3'd3: begin
                if (y == 32'd0) return D0C;
                mlo = x / y; mhi = x % y;
                return DC;
            end
            3'd4: begin mhi = x; return 0; end
            3'd5: begin mlo = x; return 0; end
            default: return 0;
        endcase
    endfunction

    // Present one start pulse and return at the next falling edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1; md_op = op; op_a = x; op_b = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Observe a fixed window: busy cycles, done pulses, done position, early HI/LO changes.
    task automatic observe(input logic [31:0] ph, input logic [31:0] pl,
                           output int nb, output int nd, output int di, output int early);
        nb = 0; nd = 0; di = -1; early = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy === 1'b1) begin
                nb++;
                if (hi !== ph || lo !== pl) early++;
            end
            if (done === 1'b1) begin
                nd++;
                di = i;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; md_op = 3'd0; op_a = '0; op_b = '0; md_use_d = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (hi !== 32'd0 || lo !== 32'd0) begin failures++; $display("FAIL reset_hilo got=%h/%h exp=0/0", hi, lo); end
        checks++; if (stall_md !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall_md); end
        reset = 1'b0; md_use_d = 1'b0;
        mhi = 32'd0; mlo = 32'd0;
    endtask

    task automatic test_mult;
        logic [2:0]  ops [2] = '{3'd0, 3'd1};
        logic [31:0] xs  [2] = '{32'hFFFFFFFE, 32'hFFFFFFFF};
        logic [31:0] ys  [2] = '{32'd3, 32'hFFFFFFFF};
        logic [31:0] eh  [2] = '{32'hFFFFFFFF, 32'hFFFFFFFE};
        logic [31:0] el  [2] = '{32'hFFFFFFFA, 32'h00000001};
        int lat, nb, nd, di, early;
        for (int k = 0; k < 2; k++) begin
            logic [31:0] ph = mhi, pl = mlo;
            lat = model(ops[k], xs[k], ys[k]);
            issue(ops[k], xs[k], ys[k]);
            observe(ph, pl, nb, nd, di, early);
            checks++; if (nb != MC) begin failures++; $display("FAIL mult%0d_busy got=%0d exp=%0d", k, nb, MC); end
            checks++; if (nd != 1 || di != MC) begin failures++; $display("FAIL mult%0d_done got=%0d@%0d exp=1@%0d", k, nd, di, MC); end
            checks++; if (early != 0) begin failures++; $display("FAIL mult%0d_early got=%0d exp=0", k, early); end
            checks++; if (hi !== eh[k] || lo !== el[k]) begin failures++; $display("FAIL mult%0d_hilo got=%h/%h exp=%h/%h", k, hi, lo, eh[k], el[k]); end
        end
    endtask

    task automatic test_div;
        logic [2:0]  ops [2] = '{3'd2, 3'd3};
        logic [31:0] xs  [2] = '{32'hFFFFFFF9, 32'd7};
        logic [31:0] ys  [2] = '{32'd2, 32'd0};
        logic [31:0] eh  [2] = '{32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] el  [2] = '{32'hFFFFFFFD, 32'hFFFFFFFD};
        int          elat[2] = '{DC, D0C};
        int lat, nb, nd, di, early;
        for (int k = 0; k < 2; k++) begin
            logic [31:0] ph = mhi, pl = mlo;
            lat = model(ops[k], xs[k], ys[k]);
            issue(ops[k], xs[k], ys[k]);
            observe(ph, pl, nb, nd, di, early);
            checks++; if (nb != elat[k]) begin failures++; $display("FAIL div%0d_busy got=%0d exp=%0d", k, nb, elat[k]); end
            checks++; if (nd != 1 || di != elat[k]) begin failures++; $display("FAIL div%0d_done got=%0d@%0d exp=1@%0d", k, nd, di, elat[k]); end
            checks++; if (hi !== eh[k] || lo !== el[k]) begin failures++; $display("FAIL div%0d_hilo got=%h/%h exp=%h/%h", k, hi, lo, eh[k], el[k]); end
        end
    endtask

    task automatic test_mthi_mtlo;
        int lat;
        md_use_d = 1'b0;
        @(negedge clk);
        start = 1'b1; md_op = 3'd4; op_a = 32'h12345678; op_b = 32'd0;
        #1;
        checks++; if (stall_md !== 1'b0) begin failures++; $display("FAIL mthi_stall got=%b exp=0", stall_md); end
        lat = model(3'd4, 32'h12345678, 32'd0);
        @(negedge clk);
        checks++; if (hi !== 32'h12345678 || busy !== 1'b0) begin failures++; $display("FAIL mthi_hi got=%h busy=%b exp=12345678 busy=0", hi, busy); end
        md_op = 3'd5; op_a = 32'h9ABCDEF0;
        lat = model(3'd5, 32'h9ABCDEF0, 32'd0);
        @(negedge clk);
        start = 1'b0;
        checks++; if (lo !== 32'h9ABCDEF0 || hi !== 32'h12345678) begin failures++; $display("FAIL mtlo_lo got=%h/%h exp=12345678/9abcdef0", hi, lo); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL mtx_busy got=%b done=%b exp=0/0", busy, done); end
    endtask

    task automatic test_stall;
        int lat;
        logic [31:0] x = $urandom, y = $urandom;
        md_use_d = 1'b1;
        lat = model(3'd0, x, y);
        @(negedge clk);
        start = 1'b1; md_op = 3'd0; op_a = x; op_b = y;
        #1;
        checks++; if (stall_md !== 1'b1) begin failures++; $display("FAIL stall_start got=%b exp=1", stall_md); end
        for (int i = 0; i < MC; i++) begin
            @(negedge clk);
            // A second launch mid-run must be ignored.
            start = (i == 2); md_op = 3'd2; op_a = $urandom; op_b = 32'd3;
            #1;
            checks++; if (busy !== 1'b1 || stall_md !== 1'b1) begin failures++; $display("FAIL stall_busy%0d got=%b/%b exp=1/1", i, busy, stall_md); end
        end
        @(negedge clk);
        start = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || stall_md !== 1'b0 || done !== 1'b1) begin failures++; $display("FAIL stall_end got=busy%b stall%b done%b exp=0/0/1", busy, stall_md, done); end
        checks++; if (hi !== mhi || lo !== mlo) begin failures++; $display("FAIL stall_hilo got=%h/%h exp=%h/%h", hi, lo, mhi, mlo); end
        md_use_d = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0 || hi !== mhi || lo !== mlo) begin failures++; $display("FAIL stall_ignored got=busy%b %h/%h exp=0 %h/%h", busy, hi, lo, mhi, mlo); end
    endtask

    task automatic test_random;
        int lat, nb, nd, di, early;
        for (int k = 0; k < 40; k++) begin
            logic [2:0]  op = 3'($urandom_range(0, 7));
            logic [31:0] x = $urandom, y = $urandom;
            logic [31:0] ph = mhi, pl = mlo;
            case ($urandom_range(0, 7))
                0: y = 32'd0;
                1: begin x = 32'h80000000; y = 32'hFFFFFFFF; end
                2: y = 32'($urandom_range(1, 9));
                default: ;
            endcase
            lat = model(op, x, y);
            issue(op, x, y);
            observe(ph, pl, nb, nd, di, early);
            checks++;
            if (nb != lat || nd != (op < 3'd4 ? 1 : 0) || (op < 3'd4 && di != lat) || early != 0) begin
                failures++;
                $display("FAIL rand%0d_timing op=%0d busy=%0d done=%0d@%0d early=%0d exp busy=%0d", k, op, nb, nd, di, early, lat);
            end
            checks++;
            if (hi !== mhi || lo !== mlo) begin
                failures++;
                $display("FAIL rand%0d_hilo op=%0d a=%h b=%h got=%h/%h exp=%h/%h", k, op, x, y, hi, lo, mhi, mlo);
            end
        end
    endtask

    task automatic test_async_reset;
        int lat, nd;
        lat = model(3'd4, 32'hA5A5A5A5, 32'd0);
        issue(3'd4, 32'hA5A5A5A5, 32'd0);
        lat = model(3'd5, 32'h5A5A5A5A, 32'd0);
        issue(3'd5, 32'h5A5A5A5A, 32'd0);
        issue(3'd2, 32'd1000, 32'd7);
        // Now in busy cycle 1; advance to busy cycle 3 and reset mid-cycle.
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b1 || hi !== 32'hA5A5A5A5) begin failures++; $display("FAIL arst_pre got=busy%b hi=%h exp=1 a5a5a5a5", busy, hi); end
        #2 reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL arst_ctrl got=%b/%b exp=0/0", busy, done); end
        checks++; if (hi !== 32'd0 || lo !== 32'd0) begin failures++; $display("FAIL arst_hilo got=%h/%h exp=0/0", hi, lo); end
        #1 reset = 1'b0;
        mhi = 32'd0; mlo = 32'd0;
        nd = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1 || hi !== 32'd0 || lo !== 32'd0) nd++;
        end
        checks++; if (nd != 0) begin failures++; $display("FAIL arst_after got=%0d cycles with activity exp=0", nd); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_mthi_mtlo();
        test_stall();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
